// File: rtl/difftest_uart_pkg.sv
// Shared types and defaults for the UART line buffer.
// A FIFO entry is one character plus a flag that marks the end of a committed line.
package difftest_uart_pkg;

  localparam logic [7:0] UART_NEWLINE = 8'h0A;

  localparam int DEFAULT_DEPTH    = 64;
  localparam int DEFAULT_MAX_LINE = 32;
  localparam int DEFAULT_TIMEOUT  = 1024;

  typedef struct packed {
    logic       last;
    logic [7:0] ch;
  } uart_entry_t;

  // Pointer width including the wrap bit, for a FIFO of the given depth.
  function automatic int ptr_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/uart_line_fifo_mem.sv
// DEPTH x 9 storage for the line buffer.
// It has one write port, one asynchronous read port, and a port that sets
// the last flag on any entry. The set port lets a line be closed after its
// final byte has already been stored.
module uart_line_fifo_mem
  import difftest_uart_pkg::*;
#(
  parameter  int DEPTH = DEFAULT_DEPTH,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clock,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_idx,
  input  logic [8:0]    wr_data,
  input  logic          set_en,
  input  logic [AW-1:0] set_idx,
  input  logic [AW-1:0] rd_idx,
  output logic [8:0]    rd_data
);

  uart_entry_t mem_q [DEPTH];
  uart_entry_t mem_d [DEPTH];

  // Next storage contents.
  // The write is applied after the set, so a write to the same index keeps
  // its own last flag.
  always_comb begin
    mem_d = mem_q;
    if (set_en) begin
      mem_d[set_idx].last = 1'b1;
    end
    if (wr_en) begin
      mem_d[wr_idx] = uart_entry_t'(wr_data);
    end
  end

  // Storage has no reset. Entries outside the committed window are never
  // presented at the output.
  always_ff @(posedge clock) begin
    mem_q <= mem_d;
  end

  assign rd_data = mem_q[rd_idx];

endmodule

// File: rtl/uart_line_buffer.sv
// Line-atomic buffer for DUT UART output.
// Every incoming byte is captured without backpressure. Bytes become visible
// to the consumer only once their line is committed. A line is committed by:
//   - a newline,
//   - reaching the MAX_LINE length,
//   - a flush,
//   - an idle timeout,
//   - a newline that had to be dropped.
// Three wrap-bit pointers track the FIFO: rd <= cm <= wr.
//   [rd, cm) holds committed bytes that are readable.
//   [cm, wr) holds the pending part of the current line.
//
// Output handshake: out_valid/out_ch/out_last describe the head entry. A byte
// transfers on a rising edge where out_valid && out_ready. out_valid never
// depends on out_ready. Once out_valid is high, it stays high until that byte
// transfers or reset is asserted.
module uart_line_buffer
  import difftest_uart_pkg::*;
#(
  parameter  int DEPTH    = DEFAULT_DEPTH,
  parameter  int MAX_LINE = DEFAULT_MAX_LINE,
  parameter  int TIMEOUT  = DEFAULT_TIMEOUT,
  localparam int PW       = ptr_width(DEPTH)
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          in_valid,
  input  logic [7:0]    in_ch,
  input  logic          flush,
  output logic          out_valid,
  output logic [7:0]    out_ch,
  output logic          out_last,
  input  logic          out_ready,
  output logic [15:0]   drop_cnt,
  output logic [PW-1:0] pending
);

  localparam int AW = PW - 1;
  localparam int IW = $clog2(TIMEOUT);

  localparam logic [PW-1:0] DEPTH_P    = PW'(DEPTH);
  localparam logic [PW-1:0] MAX_LINE_P = PW'(MAX_LINE);
  localparam logic [IW-1:0] IDLE_LIMIT = IW'(TIMEOUT - 1);

  logic [PW-1:0] wr_q, wr_d;
  logic [PW-1:0] cm_q, cm_d;
  logic [PW-1:0] rd_q, rd_d;
  logic [IW-1:0] idle_q, idle_d;
  logic [15:0]   drop_q, drop_d;

  logic          pop;
  logic          accept;
  logic          drop;
  logic          is_newline;
  logic          commit;
  logic [PW-1:0] count_after_pop;
  logic [PW-1:0] pend_cur;
  logic [PW-1:0] pend_next;
  logic          mem_wr_en;
  logic [8:0]    mem_wr_data;
  logic          mem_set_en;
  logic [AW-1:0] mem_set_idx;
  logic [8:0]    head_raw;
  uart_entry_t   head;

  // Push, pop, and commit decisions for this cycle.
  always_comb begin
    pop             = (rd_q != cm_q) && out_ready;
    count_after_pop = wr_q - rd_q - PW'(pop);
    accept          = in_valid && (count_after_pop < DEPTH_P);
    drop            = in_valid && !accept;
    is_newline      = (in_ch == UART_NEWLINE);
    wr_d            = wr_q + PW'(accept);
    pend_cur        = wr_q - cm_q;
    pend_next       = wr_d - cm_q;
    // A commit closes everything written up to and including this cycle's byte.
    commit          = (accept && (is_newline || (pend_next == MAX_LINE_P)))
                    || (flush && (pend_next != '0))
                    || ((idle_q == IDLE_LIMIT) && (pend_cur != '0))
                    || (drop && is_newline && (pend_cur != '0));
    cm_d            = commit ? wr_d : cm_q;
    rd_d            = rd_q + PW'(pop);
  end

  // Idle counter: counts edges without input while a partial line is pending.
  always_comb begin
    idle_d = '0;
    if (accept || commit) begin
      idle_d = '0;
    end else if (pend_cur != '0) begin
      idle_d = idle_q + IW'(1);
    end
  end

  // Dropped-byte counter. It saturates instead of wrapping.
  always_comb begin
    drop_d = drop_q;
    if (drop && (drop_q != 16'hFFFF)) begin
      drop_d = drop_q + 16'd1;
    end
  end

  // Storage control.
  // When the commit arrives with a new byte, that byte is written already
  // marked as last. Otherwise, the newest stored byte is marked afterwards.
  always_comb begin
    mem_wr_en   = accept;
    mem_wr_data = {commit, in_ch};
    mem_set_en  = commit && !accept;
    mem_set_idx = wr_q[AW-1:0] - AW'(1);
  end

  // Pointer, idle, and drop state. Reset discards all buffered data.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_q   <= '0;
      cm_q   <= '0;
      rd_q   <= '0;
      idle_q <= '0;
      drop_q <= '0;
    end else begin
      wr_q   <= wr_d;
      cm_q   <= cm_d;
      rd_q   <= rd_d;
      idle_q <= idle_d;
      drop_q <= drop_d;
    end
  end

  uart_line_fifo_mem #(
    .DEPTH (DEPTH)
  ) u_mem (
    .clock   (clock),
    .wr_en   (mem_wr_en),
    .wr_idx  (wr_q[AW-1:0]),
    .wr_data (mem_wr_data),
    .set_en  (mem_set_en),
    .set_idx (mem_set_idx),
    .rd_idx  (rd_q[AW-1:0]),
    .rd_data (head_raw)
  );

  assign head = uart_entry_t'(head_raw);

  // The head is presented only while committed data exists. Otherwise the
  // outputs read as zero, which keeps stale storage from reaching the port.
  always_comb begin
    out_valid = (rd_q != cm_q);
    out_ch    = out_valid ? head.ch : 8'h00;
    out_last  = out_valid ? head.last : 1'b0;
    drop_cnt  = drop_q;
    pending   = pend_cur;
  end

endmodule

// File: tb/tb_uart_line_buffer.sv
// Bench for uart_line_buffer.
// A queue-based line model predicts outputs for directed scenarios and random traffic.
module tb_uart_line_buffer;
  import difftest_uart_pkg::*;

  localparam int DEPTH    = 64;
  localparam int MAX_LINE = 32;
  localparam int TIMEOUT  = 16;
  localparam int PW       = $clog2(DEPTH) + 1;

  // ---------------- clock / reset / DUT ----------------
  logic          clock     = 1'b0;
  logic          reset_n   = 1'b0;
  logic          in_valid  = 1'b0;
  logic [7:0]    in_ch     = 8'h00;
  logic          flush     = 1'b0;
  logic          out_ready = 1'b0;
  logic          out_valid;
  logic [7:0]    out_ch;
  logic          out_last;
  logic [15:0]   drop_cnt;
  logic [PW-1:0] pending;

  always #5 clock = ~clock;

  uart_line_buffer #(
    .DEPTH    (DEPTH),
    .MAX_LINE (MAX_LINE),
    .TIMEOUT  (TIMEOUT)
  ) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ch     (in_ch),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ch    (out_ch),
    .out_last  (out_last),
    .out_ready (out_ready),
    .drop_cnt  (drop_cnt),
    .pending   (pending)
  );

  // ---------------- scoreboard / reference model ----------------
  int         n_checks = 0;
  int         n_fail   = 0;
  int         pops_dut = 0;
  logic [8:0] exp_q[$];   // committed entries {last, ch}, head first
  logic [7:0] pend_q[$];  // bytes of the line not yet committed
  int         idle_m   = 0;
  int         drop_m   = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_outputs();
    check_eq("out_valid", 32'(out_valid), 32'(exp_q.size() > 0));
    if (exp_q.size() > 0) begin
      check_eq("out_ch", 32'(out_ch), 32'(exp_q[0][7:0]));
      check_eq("out_last", 32'(out_last), 32'(exp_q[0][8]));
    end
    check_eq("pending", 32'(pending), 32'(pend_q.size()));
    check_eq("drop_cnt", 32'(drop_cnt), 32'(drop_m));
  endtask

  // Advance the line model by one clock edge, using the current inputs.
  task automatic model_step();
    bit         pop;
    bit         acc;
    bit         commit;
    int         total;
    int         pb;
    logic [7:0] b;
    pop   = out_ready && (exp_q.size() > 0);
    total = exp_q.size() + pend_q.size() - (pop ? 1 : 0);
    acc   = in_valid && (total < DEPTH);
    pb    = pend_q.size();
    if (pop) void'(exp_q.pop_front());
    if (acc) pend_q.push_back(in_ch);
    commit = (acc && (in_ch == 8'h0A || pend_q.size() == MAX_LINE))
          || (flush && pend_q.size() > 0)
          || (idle_m == TIMEOUT - 1 && pb > 0)
          || (in_valid && !acc && in_ch == 8'h0A && pb > 0);
    if (commit) begin
      while (pend_q.size() > 0) begin
        b = pend_q.pop_front();
        exp_q.push_back({pend_q.size() == 0, b});
      end
    end
    if (acc || commit) idle_m = 0;
    else if (pb > 0)   idle_m++;
    else               idle_m = 0;
    if (in_valid && !acc && drop_m < 65535) drop_m++;
  endtask

  // ---------------- driver tasks ----------------
  // Called just after a rising edge: drive, check at the falling edge, then advance.
  task automatic step(input bit v, input logic [7:0] ch, input bit fl, input bit rdy);
    in_valid  = v;
    in_ch     = ch;
    flush     = fl;
    out_ready = rdy;
    @(negedge clock);
    check_outputs();
    if (out_valid && out_ready) pops_dut++;
    model_step();
    @(posedge clock);
    #1;
  endtask

  task automatic send_str(input string s, input bit rdy);
    for (int i = 0; i < s.len(); i++) step(1'b1, s[i], 1'b0, rdy);
  endtask

  task automatic idle(input int n, input bit rdy);
    for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b0, rdy);
  endtask

  // Asynchronous reset asserted between edges; outputs must clear at once.
  task automatic do_reset();
    in_valid  = 1'b0;
    in_ch     = 8'h00;
    flush     = 1'b0;
    out_ready = 1'b0;
    reset_n   = 1'b0;
    #1;
    exp_q.delete();
    pend_q.delete();
    idle_m = 0;
    drop_m = 0;
    check_eq("rst_out_valid", 32'(out_valid), 32'd0);
    check_eq("rst_out_ch", 32'(out_ch), 32'd0);
    check_eq("rst_out_last", 32'(out_last), 32'd0);
    check_eq("rst_pending", 32'(pending), 32'd0);
    check_eq("rst_drop_cnt", 32'(drop_cnt), 32'd0);
    @(negedge clock);
    reset_n = 1'b1;
    @(posedge clock);
    #1;
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    int pv;
    int pr;
    bit v;
    bit fl;
    bit rdy;
    logic [7:0] ch;

    do_reset();

    // A short line at full rate.
    send_str("hi\n", 1'b1);
    idle(5, 1'b1);

    // Partial line closed by the idle timeout.
    do_reset();
    send_str("ab", 1'b1);
    idle(TIMEOUT - 1, 1'b1);
    check_eq("timeout_not_yet", 32'(out_valid), 32'd0);
    idle(1, 1'b1);
    check_eq("timeout_pending", 32'(pending), 32'd0);
    check_eq("timeout_head", 32'(out_ch), 32'h61);
    idle(4, 1'b1);

    // Forced commit at MAX_LINE.
    do_reset();
    for (int i = 0; i < 40; i++) step(1'b1, 8'(8'h41 + (i % 26)), 1'b0, 1'b1);
    check_eq("maxline_pending", 32'(pending), 32'd8);
    step(1'b0, 8'h00, 1'b1, 1'b1);  // flush the remainder
    idle(12, 1'b1);

    // Fill the FIFO with complete lines, drop 3, then drain.
    do_reset();
    for (int l = 0; l < 8; l++) send_str("abcdefg\n", 1'b0);
    send_str("xyz", 1'b0);
    check_eq("full_drop_cnt", 32'(drop_cnt), 32'd3);
    pops_dut = 0;
    idle(70, 1'b1);
    check_eq("drain_count", 32'(pops_dut), 32'd64);

    // Full FIFO with 5 pending bytes, then a dropped newline.
    do_reset();
    for (int l = 0; l < 7; l++) send_str("abcdefg\n", 1'b0);
    send_str("ab\n", 1'b0);
    send_str("vwxyz", 1'b0);
    check_eq("full5_pending", 32'(pending), 32'd5);
    step(1'b1, 8'h0A, 1'b0, 1'b0);
    check_eq("dropnl_pending", 32'(pending), 32'd0);
    check_eq("dropnl_drop_cnt", 32'(drop_cnt), 32'd1);
    idle(70, 1'b1);

    // Reset in the middle of a line, with committed data still unread.
    do_reset();
    send_str("012345678\n", 1'b0);
    send_str("pq", 1'b0);
    do_reset();
    send_str("z\n", 1'b1);
    idle(4, 1'b1);

    // Random traffic, in segments with varying input and drain rates.
    for (int seg = 0; seg < 20; seg++) begin
      pv = $urandom_range(0, 3);
      pv = (pv == 0) ? 0 : (pv == 1) ? 10 : (pv == 2) ? 50 : 100;
      pr = $urandom_range(0, 2);
      pr = (pr == 0) ? 0 : (pr == 1) ? 30 : 100;
      for (int c = 0; c < 200; c++) begin
        v   = ($urandom_range(0, 99) < pv);
        ch  = ($urandom_range(0, 7) == 0) ? 8'h0A : 8'($urandom_range(0, 255));
        fl  = ($urandom_range(0, 199) == 0);
        rdy = ($urandom_range(0, 99) < pr);
        step(v, ch, fl, rdy);
      end
    end
    idle(100, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
